// File: rtl/line_feeder_pkg.sv
// rtl/line_feeder_pkg.sv - shared state type, default geometry and counter sizing helpers for line_feeder
package line_feeder_pkg;

   // Frame sequencer states
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_PRIME     = 3'd1,
      ST_WAIT_INTR = 3'd2,
      ST_LINE      = 3'd3,
      ST_PAD       = 3'd4,
      ST_DONE      = 3'd5
   } lf_state_e;

   // Default frame geometry (UHD greyscale)
   localparam int LF_IMG_WIDTH   = 3840;
   localparam int LF_IMG_HEIGHT  = 2160;
   localparam int LF_PRIME_LINES = 4;
   localparam int LF_PAD_LINES   = 2;
   localparam int LF_DATA_W      = 8;
   localparam int LF_ADDR_W      = 23;

   localparam int FRAME_PIXELS = LF_IMG_WIDTH * LF_IMG_HEIGHT;

   // Bits needed to hold values 0..terminal-1; never narrower than one bit
   function automatic int cnt_w(input int terminal);
      return (terminal < 2) ? 1 : $clog2(terminal);
   endfunction

   localparam int BEAT_W  = cnt_w(LF_PRIME_LINES * LF_IMG_WIDTH);
   localparam int LINES_W = cnt_w(LF_IMG_HEIGHT + 1);
   localparam int PADS_W  = cnt_w(LF_PAD_LINES + 1);

endpackage

// File: rtl/line_feeder_rise_detect.sv
// rtl/line_feeder_rise_detect.sv - registered level input with a one-cycle rising-edge pulse
module rise_detect (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_level,
   output logic o_rise
);

   logic level_q;
   logic level_d;

   // Previous-cycle copy of the level
   always_comb begin
      level_d = i_level;
   end

   // Hold last sampled level; cleared so a level already high after reset counts as an edge
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         level_q <= 1'b0;
      end else begin
         level_q <= level_d;
      end
   end

   assign o_rise = i_level & ~level_q;

endmodule

// File: rtl/line_feeder.sv
// rtl/line_feeder.sv - interrupt-paced frame-memory pixel source; LINE_FEEDER_CYCLE_COUNT_EN adds o_cycle_count
module line_feeder
   import line_feeder_pkg::*;
#(
   parameter int IMG_WIDTH   = LF_IMG_WIDTH,
   parameter int IMG_HEIGHT  = LF_IMG_HEIGHT,
   parameter int PRIME_LINES = LF_PRIME_LINES,
   parameter int PAD_LINES   = LF_PAD_LINES,
   parameter int DATA_W      = LF_DATA_W,
   parameter int ADDR_W      = LF_ADDR_W
) (
`ifdef LINE_FEEDER_CYCLE_COUNT_EN
   output logic [31:0]       o_cycle_count,
`endif
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_start,
   input  logic              i_intr,
   output logic              o_mem_rd,
   output logic [ADDR_W-1:0] o_mem_addr,
   input  logic [DATA_W-1:0] i_mem_data,
   output logic [DATA_W-1:0] o_data,
   output logic              o_data_valid,
   output logic              o_busy,
   output logic              o_done
);

   localparam int BEAT_BITS  = cnt_w(PRIME_LINES * IMG_WIDTH);
   localparam int LINES_BITS = cnt_w(IMG_HEIGHT + 1);
   localparam int PADS_BITS  = cnt_w(PAD_LINES + 1);

   localparam logic [BEAT_BITS-1:0]  PRIME_LAST   = BEAT_BITS'(PRIME_LINES * IMG_WIDTH - 1);
   localparam logic [BEAT_BITS-1:0]  LINE_LAST    = BEAT_BITS'(IMG_WIDTH - 1);
   localparam logic [LINES_BITS-1:0] LINES_END    = LINES_BITS'(IMG_HEIGHT);
   localparam logic [LINES_BITS-1:0] LINES_PRIMED = LINES_BITS'(PRIME_LINES);
   localparam logic [PADS_BITS-1:0]  PADS_END     = PADS_BITS'(PAD_LINES);

   lf_state_e              state_q, state_d;
   logic [ADDR_W-1:0]      addr_q, addr_d;
   logic [BEAT_BITS-1:0]   beat_q, beat_d;
   logic [LINES_BITS-1:0]  lines_q, lines_d, lines_n;
   logic [PADS_BITS-1:0]   pads_q, pads_d, pads_n;
   logic                   pend_q, pend_d;
   logic                   valid_q, valid_d;
   logic                   pad_sel_q, pad_sel_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   intr_rise;
   logic                   issue;
   logic                   burst_last;
   logic                   go;

   rise_detect u_intr_rise (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_level (i_intr),
      .o_rise  (intr_rise)
   );

   // Which burst an interrupt releases, given what has already been sent
   function automatic lf_state_e next_burst(input logic [LINES_BITS-1:0] l,
                                            input logic [PADS_BITS-1:0]  p);
      if (l < LINES_END) begin
         return ST_LINE;
      end else if (p < PADS_END) begin
         return ST_PAD;
      end else begin
         return ST_DONE;
      end
   endfunction

   // Sequencer: bursts, address walk, line/pad accounting and the single pending interrupt
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      beat_d     = beat_q;
      lines_d    = lines_q;
      pads_d     = pads_q;
      pend_d     = pend_q;
      busy_d     = busy_q;
      lines_n    = lines_q;
      pads_n     = pads_q;
      issue      = (state_q == ST_PRIME) || (state_q == ST_LINE) || (state_q == ST_PAD);
      burst_last = (state_q == ST_PRIME) ? (beat_q == PRIME_LAST) : (beat_q == LINE_LAST);
      go         = pend_q | intr_rise;

      case (state_q)
         ST_IDLE: begin
            pend_d = 1'b0;
            if (i_start) begin
               state_d = ST_PRIME;
               addr_d  = '0;
               beat_d  = '0;
               lines_d = '0;
               pads_d  = '0;
               busy_d  = 1'b1;
            end
         end
         ST_WAIT_INTR: begin
            if (go) begin
               pend_d  = 1'b0;
               state_d = next_burst(lines_q, pads_q);
            end
         end
         ST_PRIME, ST_LINE, ST_PAD: begin
            if (state_q != ST_PAD) begin
               addr_d = addr_q + ADDR_W'(1);
            end
            if (!burst_last) begin
               beat_d = beat_q + BEAT_BITS'(1);
               // A second edge while one is already pending is dropped
               pend_d = go;
            end else begin
               beat_d = '0;
               if (state_q == ST_PRIME) begin
                  lines_n = LINES_PRIMED;
               end else if (state_q == ST_LINE) begin
                  lines_n = lines_q + LINES_BITS'(1);
               end else begin
                  pads_n = pads_q + PADS_BITS'(1);
               end
               lines_d = lines_n;
               pads_d  = pads_n;
               pend_d  = 1'b0;
               // Chain straight into the pending burst so back-to-back lines have no gap
               if (next_burst(lines_n, pads_n) == ST_DONE) begin
                  state_d = ST_DONE;
               end else if (go) begin
                  state_d = next_burst(lines_n, pads_n);
               end else begin
                  state_d = ST_WAIT_INTR;
               end
            end
         end
         ST_DONE: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      valid_d   = issue;
      pad_sel_d = (state_q == ST_PAD);
      done_d    = (state_q == ST_DONE);
   end

   // State and output registers; reset aborts any frame in flight
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         beat_q    <= '0;
         lines_q   <= '0;
         pads_q    <= '0;
         pend_q    <= 1'b0;
         valid_q   <= 1'b0;
         pad_sel_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         beat_q    <= beat_d;
         lines_q   <= lines_d;
         pads_q    <= pads_d;
         pend_q    <= pend_d;
         valid_q   <= valid_d;
         pad_sel_q <= pad_sel_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   // Memory read data is already registered; the pad bit and valid mask it to zero
   assign o_mem_rd     = (state_q == ST_PRIME) || (state_q == ST_LINE);
   assign o_mem_addr   = addr_q;
   assign o_data_valid = valid_q;
   assign o_data       = (valid_q && !pad_sel_q) ? i_mem_data : '0;
   assign o_busy       = busy_q;
   assign o_done       = done_q;

`ifdef LINE_FEEDER_CYCLE_COUNT_EN
   logic [31:0] cyc_cnt_q, cyc_cnt_d;
   logic        cyc_run_q, cyc_run_d;

   // Count from the cycle after the prime burst through the o_done cycle, then hold
   always_comb begin
      cyc_cnt_d = cyc_cnt_q;
      cyc_run_d = cyc_run_q;
      if (cyc_run_q) begin
         cyc_cnt_d = cyc_cnt_q + 32'd1;
      end
      if (done_q) begin
         cyc_run_d = 1'b0;
      end
      if ((state_q == ST_PRIME) && burst_last) begin
         cyc_run_d = 1'b1;
      end
      if ((state_q == ST_IDLE) && i_start) begin
         cyc_cnt_d = '0;
         cyc_run_d = 1'b0;
      end
   end

   // Cycle counter registers
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         cyc_cnt_q <= '0;
         cyc_run_q <= 1'b0;
      end else begin
         cyc_cnt_q <= cyc_cnt_d;
         cyc_run_q <= cyc_run_d;
      end
   end

   assign o_cycle_count = cyc_cnt_q;
`endif

endmodule

// File: doc/line_feeder.md
Name: line_feeder

Overview:
- Hardware pixel source for the convolution pipeline (imageProcessTop followed by box_filter).
- Reads an 8-bit greyscale frame from a synchronous frame memory and streams it onto the pipeline's slave pixel interface.
- Follows the interrupt-paced line protocol: prime with PRIME_LINES lines, then send one line per rising edge of o_intr, then append PAD_LINES zero lines, each also on its own interrupt.
- Replaces software or bench stimulus so the filter chain can run stand-alone on the FPGA.

Parameters:
- IMG_WIDTH, 3840, pixels per line.
- IMG_HEIGHT, 2160, lines per frame; must be >= PRIME_LINES.
- PRIME_LINES, 4, lines sent back-to-back before the first interrupt wait.
- PAD_LINES, 2, zero-valued lines appended after the last image line.
- DATA_W, 8, pixel width.
- ADDR_W, 23, frame memory address width; must satisfy 2^ADDR_W >= IMG_WIDTH*IMG_HEIGHT.

Ports:
- i_clk  in  1  single clock for all logic.
- i_reset  in  1  asynchronous, active-high reset.
- i_start  in  1  one-cycle pulse; starts a frame when idle.
- i_intr  in  1  line-consumed interrupt from the image processor (level; rising edge is the event).
- o_mem_rd  out  1  frame-memory read enable.
- o_mem_addr  out  ADDR_W  read address, linear raster order, first pixel at 0.
- i_mem_data  in  DATA_W  read data, valid exactly one cycle after o_mem_rd.
- o_data  out  DATA_W  pixel to the processor.
- o_data_valid  out  1  pixel valid; downstream always accepts.
- o_busy  out  1  high from the cycle after i_start until o_done.
- o_done  out  1  one-cycle pulse after the final pad pixel.

Behaviour:
- Reset (asynchronous, immediate):
  - all outputs 0; state IDLE; counters and pending-interrupt flag cleared.
  - Reset mid-frame aborts the frame; no residual valid is produced.
- States: IDLE, PRIME, WAIT_INTR, LINE, PAD, DONE.
- IDLE:
  - i_start moves to PRIME next cycle.
  - i_start is ignored in every other state.
- PRIME:
  - o_mem_rd is high for PRIME_LINES*IMG_WIDTH consecutive cycles; o_mem_addr increments by 1 each cycle from 0.
  - Then goes to WAIT_INTR.
- WAIT_INTR:
  - Rising-edge detect is i_intr AND NOT registered i_intr.
  - On an edge, or if the pending flag is set (flag is consumed), goes to LINE if lines_sent < IMG_HEIGHT, else PAD if pads_sent < PAD_LINES, else DONE.
- LINE:
  - IMG_WIDTH consecutive reads, continuing the address count; then lines_sent += 1 and back to WAIT_INTR.
- PAD:
  - IMG_WIDTH cycles of zero pixels; no memory read.
  - A pad-select bit travels with the read pipeline and forces o_data to 0.
  - Then pads_sent += 1 and back to WAIT_INTR.
- DONE:
  - o_done pulses for 1 cycle; o_busy drops in the same cycle; returns to IDLE.
- Latency:
  - o_data_valid and o_data are registered, exactly one cycle behind o_mem_rd (or behind the pad-issue strobe).
  - Interrupt edge sampled at cycle k gives first issue at k+1 and first o_data_valid at k+2.
- Interrupt edge during PRIME, LINE or PAD:
  - sets the pending flag (at most one pending; further edges are dropped).
  - The pending line starts the cycle after the current burst ends, so back-to-back lines have no gap.
- o_data_valid bursts are exactly IMG_WIDTH long (PRIME: PRIME_LINES*IMG_WIDTH), with no internal gaps.
- Totals: o_data_valid high for (IMG_HEIGHT+PAD_LINES)*IMG_WIDTH cycles per frame; last address issued is IMG_WIDTH*IMG_HEIGHT-1.
- Counter widths are sized with $clog2 of the terminal counts; no wrap is possible within a frame.

Optional Feature:
- LINE_FEEDER_CYCLE_COUNT_EN
  - Defined: adds output o_cycle_count (32 bits).
    - Cleared on i_start.
    - Counts every cycle from the first cycle of WAIT_INTR after PRIME up to and including the o_done cycle.
    - Held until the next i_start; reset value 0.
  - Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package line_feeder_pkg holds:
  - the state enum typedef;
  - localparam helpers: FRAME_PIXELS = IMG_WIDTH*IMG_HEIGHT, and the counter widths via $clog2.
- One natural sub-module: rise_detect (registered level input, one-cycle edge pulse, asynchronous active-high reset). Instantiated for i_intr.

Test Plan (IMG_WIDTH=8, IMG_HEIGHT=6, PRIME_LINES=4, PAD_LINES=2, memory holds pixel value = address):
- i_start pulse, no i_intr:
  - exactly 32 valids, values 0..31, contiguous;
  - then o_data_valid stays 0 and o_busy stays 1 indefinitely.
- After prime, i_intr rising at cycle k:
  - o_mem_rd at k+1 with address 32;
  - o_data_valid at k+2 with values 32..39 over 8 cycles.
- Full frame with 4 interrupt edges:
  - data 0..47, then 16 zero pixels;
  - o_done a single cycle after the last zero pixel;
  - total 64 valids.
- Two interrupt edges inside one LINE burst:
  - second line follows with no gap cycle;
  - the extra edge is dropped, so the next line waits for a new edge.
- i_reset asserted mid-LINE:
  - o_data_valid, o_mem_rd and o_busy are 0 the same cycle;
  - a new i_start restarts at address 0.
- With LINE_FEEDER_CYCLE_COUNT_EN and a fixed 20-cycle interrupt spacing: o_cycle_count matches the golden cycle count from the bench's model.
